rle_lane_sched: RTL

RLE_LANE_SCHED -- requirements
Module: rle_lane_sched

---
 rtl/rle_pkg.sv | 20 ++
 rtl/rle_run_merge.sv | 25 ++
 rtl/rle_lane_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE lane scheduler: state encoding, special
// output words and default geometry.
package rle_pkg;

    localparam int LANES_DEF   = 8;
    localparam int SYM_MAX_DEF = 5;
    localparam int ADDR_W_DEF  = 9;
    localparam int RUN_MAX     = 63;

    localparam logic [15:0] ESC_WORD = 16'hFC00;
    localparam logic [15:0] EOB_WORD = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2,
        ST_EOB  = 2'd3
    } state_t;

endpackage

// File: rtl/rle_run_merge.sv
// Folds the pending zero-run carry into the run field of a lane's first
// symbol. When the merged run no longer fits in six bits an escape word is
// needed and the remainder becomes the new carry.
module rle_run_merge
    import rle_pkg::*;
(
    input  logic [6:0] carry_in,
    input  logic [5:0] run_in,
    input  logic       run_zero,
    output logic       esc,
    output logic [5:0] run_out,
    output logic [6:0] carry_out
);

    logic [7:0] sum;

    // Add carry to run (run forced to zero once an escape has been issued)
    always_comb begin
        sum       = {1'b0, carry_in} + {2'b00, (run_zero ? 6'd0 : run_in)};
        esc       = (sum > 8'(RUN_MAX));
        run_out   = sum[5:0];
        carry_out = esc ? 7'(sum - 8'(RUN_MAX + 1)) : 7'd0;
    end

endmodule

// File: rtl/rle_lane_sched.sv
// Drains the RLE lanes of one block in order, merging trailing-zero runs
// across lanes, and streams the resulting 16-bit words into a circular SRAM
// region terminated by an end-of-block word.
module rle_lane_sched
    import rle_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int SYM_MAX = SYM_MAX_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LANES-1:0]  lane_valid,
    output logic [2:0]        lane_sel,
    output logic [2:0]        sym_idx,
    input  logic [15:0]       sym_data,
    input  logic [2:0]        lane_cnt,
    input  logic [3:0]        lane_tail,
    output logic              lane_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              busy,
    output logic              done,
    output logic [5:0]        word_cnt
);

    state_t            state;
    logic [2:0]        lane;
    logic [2:0]        k;
    logic [2:0]        cnt_r;
    logic [3:0]        tail_r;
    logic [6:0]        carry;
    logic [ADDR_W-1:0] ptr;
    logic [5:0]        wcnt;
    logic              esc_pend;

    logic              esc;
    logic [5:0]        run_merged;
    logic [6:0]        carry_next;
    logic              cur_valid;
    logic              last_lane;
    logic [2:0]        cnt_clamp;
    logic              emit_sym;
    logic              emit_last;

    rle_run_merge u_merge (
        .carry_in  (carry),
        .run_in    (sym_data[15:10]),
        .run_zero  (esc_pend),
        .esc       (esc),
        .run_out   (run_merged),
        .carry_out (carry_next)
    );

    // Lane status and end-of-lane decode for the current cycle
    always_comb begin
        cur_valid = lane_valid[lane];
        last_lane = (lane == 3'(LANES - 1));
        cnt_clamp = (lane_cnt > 3'(SYM_MAX)) ? 3'(SYM_MAX) : lane_cnt;
        emit_sym  = (state == ST_EMIT) && !((k == 3'd0) && esc);
        emit_last = emit_sym && (k == (cnt_r - 3'd1));
    end

    // Output decode from the current state; everything idles at zero
    always_comb begin
        mem_we   = 1'b0;
        mem_din  = 16'h0000;
        lane_ack = 1'b0;
        done     = 1'b0;
        case (state)
            ST_WAIT: begin
                lane_ack = cur_valid && (lane_cnt == 3'd0);
            end
            ST_EMIT: begin
                mem_we = 1'b1;
                if (k != 3'd0)
                    mem_din = sym_data;
                else if (esc)
                    mem_din = ESC_WORD;
                else
                    mem_din = {run_merged, sym_data[9:0]};
                lane_ack = emit_last;
            end
            ST_EOB: begin
                mem_we  = 1'b1;
                mem_din = EOB_WORD;
                done    = 1'b1;
            end
            default: ;
        endcase
        lane_sel = lane;
        sym_idx  = k;
        mem_addr = ptr;
        busy     = (state != ST_IDLE);
    end

    // Scheduler state, carry tracking and write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            lane     <= 3'd0;
            k        <= 3'd0;
            cnt_r    <= 3'd0;
            tail_r   <= 4'd0;
            carry    <= 7'd0;
            ptr      <= '0;
            wcnt     <= 6'd0;
            word_cnt <= 6'd0;
            esc_pend <= 1'b0;
        end else begin
            if (mem_we) begin
                ptr  <= ptr + 1'b1;
                wcnt <= wcnt + 6'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WAIT;
                        lane  <= 3'd0;
                        k     <= 3'd0;
                        carry <= 7'd0;
                        wcnt  <= 6'd0;
                    end
                end
                ST_WAIT: begin
                    if (cur_valid) begin
                        if (lane_cnt == 3'd0) begin
                            carry <= carry + 7'(lane_tail);
                            if (last_lane)
                                state <= ST_EOB;
                            else
                                lane <= lane + 3'd1;
                        end else begin
                            state    <= ST_EMIT;
                            k        <= 3'd0;
                            cnt_r    <= cnt_clamp;
                            tail_r   <= lane_tail;
                            esc_pend <= 1'b0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (!emit_sym) begin
                        carry    <= carry_next;
                        esc_pend <= 1'b1;
                    end else if (emit_last) begin
                        carry <= 7'(tail_r);
                        k     <= 3'd0;
                        if (last_lane) begin
                            state <= ST_EOB;
                        end else begin
                            state <= ST_WAIT;
                            lane  <= lane + 3'd1;
                        end
                    end else begin
                        if (k == 3'd0)
                            carry <= 7'd0;
                        k <= k + 3'd1;
                    end
                end
                ST_EOB: begin
                    word_cnt <= wcnt + 6'd1;
                    state    <= ST_IDLE;
                    lane     <= 3'd0;
                    k        <= 3'd0;
                    carry    <= 7'd0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
